// File: rtl/morse_letter_tx.sv
// Morse-code letter transmitter (A-Z from a 5-bit switch code) driving one LED.
// Build option: define MORSE_REPEAT_EN to repeat the letter until KEY[1] is pressed again.
module morse_letter_tx #(
   parameter int DOT_CYCLES = 25_000_000,
   parameter int DASH_UNITS = 3,
   parameter int LGAP_UNITS = 3,
   parameter int CNT_W      = $clog2(DOT_CYCLES *
                                     ((DASH_UNITS > LGAP_UNITS) ? DASH_UNITS : LGAP_UNITS))
) (
   input  logic       CLOCK_50,
   input  logic [1:0] KEY,
   input  logic [4:0] SW,
   output logic [2:0] LEDR
);

   localparam logic [CNT_W-1:0] DOT_LAST  = CNT_W'(DOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DASH_LAST = CNT_W'(DASH_UNITS * DOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LGAP_LAST = CNT_W'(LGAP_UNITS * DOT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      MARK  = 3'd2,
      SPACE = 3'd3,
      LGAP  = 3'd4,
      DONE  = 3'd5
   } state_t;

   logic             w_rstN;
   logic [5:0]       w_rom;
   logic             w_valid;
   logic [CNT_W-1:0] w_markLast;

   logic             r_meta;
   logic             r_sync;
   logic             r_prev;
   logic [1:0]       r_vld;
   logic             r_start;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_idx;
   logic [1:0]       r_lastIdx;
   logic [3:0]       r_pat;
   logic             r_light;
   logic             r_busy;
   logic             r_done;
`ifdef MORSE_REPEAT_EN
   logic             r_stop;
`endif

   assign w_rstN = KEY[0];
   assign LEDR   = {r_done, r_busy, r_light};

   // ROM entry = {last symbol index, pattern}; pattern bit i is symbol i, 1 = dash.
   always_comb begin
      w_rom = 6'b00_0000;
      case (SW)
         5'd0:    w_rom = 6'b01_0010;
         5'd1:    w_rom = 6'b11_0001;
         5'd2:    w_rom = 6'b11_0101;
         5'd3:    w_rom = 6'b10_0001;
         5'd4:    w_rom = 6'b00_0000;
         5'd5:    w_rom = 6'b11_0100;
         5'd6:    w_rom = 6'b10_0011;
         5'd7:    w_rom = 6'b11_0000;
         5'd8:    w_rom = 6'b01_0000;
         5'd9:    w_rom = 6'b11_1110;
         5'd10:   w_rom = 6'b10_0101;
         5'd11:   w_rom = 6'b11_0010;
         5'd12:   w_rom = 6'b01_0011;
         5'd13:   w_rom = 6'b01_0001;
         5'd14:   w_rom = 6'b10_0111;
         5'd15:   w_rom = 6'b11_0110;
         5'd16:   w_rom = 6'b11_1011;
         5'd17:   w_rom = 6'b10_0010;
         5'd18:   w_rom = 6'b10_0000;
         5'd19:   w_rom = 6'b00_0001;
         5'd20:   w_rom = 6'b10_0100;
         5'd21:   w_rom = 6'b11_1000;
         5'd22:   w_rom = 6'b10_0110;
         5'd23:   w_rom = 6'b11_1001;
         5'd24:   w_rom = 6'b11_1101;
         5'd25:   w_rom = 6'b11_0011;
         default: w_rom = 6'b00_0000;
      endcase
   end

   assign w_valid    = (SW < 5'd26);
   assign w_markLast = r_pat[r_idx] ? DASH_LAST : DOT_LAST;

   // The reset-time 1s in the synchronizer are not real samples, so the edge
   // detector only arms once r_sync holds a value actually taken from the pin;
   // a button held through reset therefore never fires.
   always_ff @(posedge CLOCK_50 or negedge w_rstN) begin
      if (!w_rstN) begin
         r_meta  <= 1'b1;
         r_sync  <= 1'b1;
         r_prev  <= 1'b0;
         r_vld   <= 2'b00;
         r_start <= 1'b0;
      end else begin
         r_meta  <= KEY[1];
         r_sync  <= r_meta;
         r_vld   <= {r_vld[0], 1'b1};
         r_prev  <= r_vld[1] & r_sync;
         r_start <= r_prev & ~r_sync;
      end
   end

   // Busy is the registered "not idle" state, so it trails the FSM by one cycle.
   always_ff @(posedge CLOCK_50 or negedge w_rstN) begin
      if (!w_rstN) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_idx     <= 2'd0;
         r_lastIdx <= 2'd0;
         r_pat     <= 4'd0;
         r_light   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
`ifdef MORSE_REPEAT_EN
         r_stop    <= 1'b0;
`endif
      end else begin
         r_busy <= (r_state != IDLE);
`ifdef MORSE_REPEAT_EN
         if (r_state == IDLE) begin
            r_stop <= 1'b0;
         end else if (r_start) begin
            r_stop <= 1'b1;
         end
`endif
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (r_start) begin
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               r_cnt     <= '0;
               r_idx     <= 2'd0;
               r_lastIdx <= w_rom[5:4];
               r_pat     <= w_rom[3:0];
               if (w_valid) begin
                  r_state <= MARK;
                  r_light <= 1'b1;
               end else begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end
            end
            MARK: begin
               if (r_cnt == w_markLast) begin
                  r_cnt   <= '0;
                  r_light <= 1'b0;
                  r_state <= (r_idx == r_lastIdx) ? LGAP : SPACE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            SPACE: begin
               if (r_cnt == DOT_LAST) begin
                  r_cnt   <= '0;
                  r_idx   <= r_idx + 2'd1;
                  r_light <= 1'b1;
                  r_state <= MARK;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            LGAP: begin
               if (r_cnt == LGAP_LAST) begin
                  r_cnt <= '0;
`ifdef MORSE_REPEAT_EN
                  if (r_stop) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= LOAD;
                  end
`else
                  r_state <= DONE;
                  r_done  <= 1'b1;
`endif
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               r_cnt   <= '0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_cnt   <= '0;
               r_light <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_morse_letter_tx.sv
// Directed bench for morse_letter_tx with DOT_CYCLES=4 (dot 4, dash 12, letter gap 12 cycles).
// Define MORSE_REPEAT_EN for both files to exercise the repeat build instead of single-shot.
module tb_morse_letter_tx;

   logic       clk = 1'b0;
   logic [1:0] key;
   logic [4:0] sw;
   logic [2:0] ledr;

   int   checks   = 0;
   int   failures = 0;
   int   obsRuns[16];
   int   obsN;
   logic doneSeen;

   always #5 clk = ~clk;

   morse_letter_tx #(.DOT_CYCLES(4)) dut (
      .CLOCK_50 (clk),
      .KEY      (key),
      .SW       (sw),
      .LEDR     (ledr)
   );

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // Press KEY[1] so that the first low sample is the next rising edge.
   task automatic applyStimulus(input logic [4:0] code);
      @(negedge clk);
      sw     = code;
      key[1] = 1'b0;
      repeat (3) @(negedge clk);
      key[1] = 1'b1;
   endtask

   task automatic startLetter(input string tag, input logic [4:0] code);
      applyStimulus(code);
      @(negedge clk);
      checkOutput({tag, "_load"}, int'(ledr), 0);
      @(negedge clk);
      checkOutput({tag, "_firstMark"}, int'(ledr), 3);
   endtask

   // Run lengths of LEDR[0], starting with the current sample, until done or maxRuns.
   task automatic captureRuns(input int maxRuns);
      int   len;
      int   budget;
      logic cur;
      len      = 1;
      budget   = 0;
      cur      = ledr[0];
      obsN     = 0;
      doneSeen = 1'b0;
      foreach (obsRuns[i]) obsRuns[i] = 0;
      while (!doneSeen && obsN < maxRuns && budget < 400) begin
         @(negedge clk);
         budget++;
         if (ledr[2]) begin
            obsRuns[obsN] = len;
            obsN++;
            doneSeen = 1'b1;
         end else if (ledr[0] == cur) begin
            len++;
         end else begin
            obsRuns[obsN] = len;
            obsN++;
            cur = ledr[0];
            len = 1;
         end
      end
      if (!doneSeen && obsN < maxRuns) checkOutput("captureTimeout", budget, 0);
   endtask

   task automatic checkRuns(input string tag, input int expN, input int expRuns[8]);
      checkOutput({tag, "_runCount"}, obsN, expN);
      for (int i = 0; i < expN; i++) begin
         checkOutput($sformatf("%s_run%0d", tag, i), obsRuns[i], expRuns[i]);
      end
   endtask

   task automatic checkTail(input string tag);
      checkOutput({tag, "_doneSeen"}, int'(doneSeen), 1);
      @(negedge clk);
      checkOutput({tag, "_busyTail"}, int'(ledr), 2);
      @(negedge clk);
      checkOutput({tag, "_idle"}, int'(ledr), 0);
   endtask

   task automatic checkQuiet(input string tag, input int cycles);
      int active;
      active = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (ledr != 3'b000) active++;
      end
      checkOutput(tag, active, 0);
   endtask

   initial begin
      key = 2'b10;
      sw  = 5'd0;
      #1;
      checkOutput("resetLedr", int'(ledr), 0);
      repeat (3) @(negedge clk);
      key[0] = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("idleAfterReset", int'(ledr), 0);

      // KEY[1] held low across reset release must not start a letter.
      @(negedge clk);
      key = 2'b00;
      repeat (2) @(negedge clk);
      key[0] = 1'b1;
      checkQuiet("heldKeyNoStart", 20);
      key[1] = 1'b1;
      repeat (3) @(negedge clk);

      // Invalid code: busy for two cycles, done pulse, light never on.
      applyStimulus(5'd27);
      @(negedge clk);
      checkOutput("inv_load", int'(ledr), 0);
      @(negedge clk);
      checkOutput("inv_done", int'(ledr), 6);
      @(negedge clk);
      checkOutput("inv_busyTail", int'(ledr), 2);
      @(negedge clk);
      checkOutput("inv_idle", int'(ledr), 0);
      checkQuiet("inv_quiet", 5);

`ifndef MORSE_REPEAT_EN
      startLetter("E", 5'd4);
      captureRuns(8);
      checkRuns("E", 2, '{4, 12, 0, 0, 0, 0, 0, 0});
      checkTail("E");

      startLetter("A", 5'd0);
      captureRuns(8);
      checkRuns("A", 4, '{4, 4, 12, 12, 0, 0, 0, 0});
      checkTail("A");

      // Q, with SW moved to E partway through the letter.
      startLetter("Q", 5'd16);
      fork
         begin
            repeat (6) @(negedge clk);
            sw = 5'd4;
         end
         captureRuns(8);
      join
      checkRuns("Q", 8, '{12, 4, 12, 4, 4, 4, 12, 12});
      checkTail("Q");

      // Reset in the middle of A's dash, then replay A from its first dot.
      startLetter("rstA", 5'd0);
      repeat (10) @(negedge clk);
      checkOutput("rstA_inDash", int'(ledr), 3);
      #1 key[0] = 1'b0;
      #1 checkOutput("rstA_async", int'(ledr), 0);
      @(negedge clk);
      key[0] = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("rstA_idle", int'(ledr), 0);
      startLetter("replayA", 5'd0);
      captureRuns(8);
      checkRuns("replayA", 4, '{4, 4, 12, 12, 0, 0, 0, 0});
      checkTail("replayA");

      // A second press during MARK is ignored.
      startLetter("ignA", 5'd0);
      fork
         begin
            repeat (2) @(negedge clk);
            key[1] = 1'b0;
            repeat (3) @(negedge clk);
            key[1] = 1'b1;
         end
         captureRuns(8);
      join
      checkRuns("ignA", 4, '{4, 4, 12, 12, 0, 0, 0, 0});
      checkTail("ignA");
      checkQuiet("ignA_noSecondLetter", 30);
`else
      // Dark time between repeats includes the one-cycle reload.
      sw = 5'd4;
      startLetter("repE", 5'd4);
      captureRuns(3);
      checkRuns("repE", 3, '{4, 13, 4, 0, 0, 0, 0, 0});
      sw = 5'd19;
      captureRuns(4);
      checkRuns("repT", 4, '{13, 12, 13, 12, 0, 0, 0, 0});
      fork
         begin
            key[1] = 1'b0;
            repeat (3) @(negedge clk);
            key[1] = 1'b1;
         end
         captureRuns(4);
      join
      checkRuns("repStop", 1, '{12, 0, 0, 0, 0, 0, 0, 0});
      checkTail("repStop");
      checkQuiet("repStop_quiet", 30);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/morse_letter_tx.md
# morse_letter_tx

Parametrised Morse-code letter transmitter for the DE1 lab board, the general successor to the 8-letter fixed-timing Morse display. It covers the full A–Z alphabet from a 5-bit switch code, with configurable unit timing and dash/gap ratios. It uses a single-clock FSM with start edge detection, busy/done status and an optional continuous-repeat mode. It drives one LED as the Morse light and sits directly under the board top level, fed from SW/KEY.

## Interface
- DOT_CYCLES, 25_000_000: clock cycles per Morse unit (0.5 s at 50 MHz); must be ≥ 2.
- DASH_UNITS, 3: units per dash mark.
- LGAP_UNITS, 3: units of dark inter-letter gap after the last symbol.
- CNT_W, $clog2(DOT_CYCLES*max(DASH_UNITS,LGAP_UNITS)): width of the duration counter.
- CLOCK_50  in  1  system clock; the only clock; all logic on its rising edge.
- KEY  in  2  KEY[0] = active-low **asynchronous** reset. KEY[1] = active-low start pushbutton (asynchronous to clock, not debounced).
- SW  in  5  letter code: 0 = A … 25 = Z; 26–31 invalid.
- LEDR  out  3  [0] Morse light, [1] busy, [2] done (one-cycle pulse).

## Operation
- Internal ROM maps code to length L (1–4) and a pattern (bit i: 1 = dash, 0 = dot), using standard International Morse for A–Z.
- KEY[1] passes through a 2-FF synchronizer. A 1→0 transition of the synchronized value produces a one-cycle start pulse.
- FSM states and transitions:
  - IDLE → LOAD on start.
  - LOAD latches SW, L and the pattern, and sets symbol index 0.
    - Valid code → MARK.
    - Invalid code → DONE.
  - MARK holds LEDR[0]=1 for DOT_CYCLES (dot) or DASH_UNITS*DOT_CYCLES (dash) cycles.
    - Not last symbol → SPACE.
    - Last symbol → LGAP.
  - SPACE is dark for DOT_CYCLES cycles, then index+1 → MARK.
  - LGAP is dark for LGAP_UNITS*DOT_CYCLES cycles, then → DONE.
  - DONE lasts one cycle with LEDR[2]=1, then → IDLE.
- LEDR[1] = 1 in every state except IDLE.
- Start pulses outside IDLE are ignored (non-repeat build).
- SW changes after LOAD have no effect on the letter in flight.
- Duration counter clears on every state entry. A phase of N cycles ends when the counter reaches N-1; no off-by-one is allowed.

## Timing
- Reset asserted (KEY[0]=0), at any time including mid-MARK: state=IDLE, counter=0, LEDR=3'b000 immediately, with no clock needed.
- Reset release: IDLE on the first following edge; synchronizer flops reset to 1 so a held KEY[1] does not fire.
- KEY[1] first sampled low at edge N:
  - start pulse after edge N+2;
  - LOAD at edge N+3;
  - LEDR[0]/LEDR[1] high from edge N+4.
- Symbol widths are exact cycle counts:
  - dot = DOT_CYCLES;
  - dash = DASH_UNITS*DOT_CYCLES;
  - intra gap = DOT_CYCLES;
  - letter gap = LGAP_UNITS*DOT_CYCLES.
- Invalid code: LOAD → DONE. Busy lasts 2 cycles, LEDR[0] never rises, and LEDR[2] pulses.

## Configuration
- MORSE_REPEAT_EN defined:
  - LGAP exit goes to LOAD instead of DONE, so the letter repeats indefinitely. SW is re-sampled at each LOAD, so letter changes take effect at letter boundaries.
  - A start pulse while busy sets a stop flag. The current letter finishes, then LGAP → DONE → IDLE.
  - An invalid code at a re-LOAD goes to DONE.
- Not defined: single-shot behaviour as above; no stop flag logic is present.

## Test plan
- DOT_CYCLES=4, SW=4 (E), press KEY[1] → LEDR[0] high 4 cycles, dark 12, LEDR[2] pulse 1 cycle, LEDR[1] low after.
- SW=0 (A) → LEDR[0] high 4, low 4, high 12, low 12, then done. SW=16 (Q) → marks 12/12/4/12 separated by 4-cycle gaps.
- SW=27 → LEDR[0] stays 0, LEDR[1] high exactly 2 cycles, one LEDR[2] pulse.
- Assert KEY[0] in the middle of the dash of A → LEDR=000 without a clock edge; after release, a new press replays A from its first dot.
- Non-repeat: press KEY[1] again during MARK → ignored, exactly one done pulse. Hold KEY[1] low through reset release → no start.
- MORSE_REPEAT_EN, SW=4 → E repeats with a 12-cycle gap. Change SW to 19 (T) mid-letter → next letter is a 12-cycle dash. Press KEY[1] → current letter completes, then a single done pulse and IDLE.
